// File: rtl/shim_sts_pkg.sv
// ============================================================================
// Package     : shim_sts_pkg
// Description : Shared constants and helpers for the status CDC front-end
//               (shim_sts_sync_latch and shim_sts_sync_field).
// Contents    : DEFAULT_SYNC_DEPTH, DEFAULT_STABLE_COUNT, clog2_min1()
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shim_sts_pkg;

   localparam int DEFAULT_SYNC_DEPTH   = 3;
   localparam int DEFAULT_STABLE_COUNT = 2;

   // Ceiling log2 clamped to at least 1, so an index port never collapses to
   // zero width when there is only a single field.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage : shim_sts_pkg

`default_nettype wire

// File: rtl/shim_sts_sync_field.sv
// ============================================================================
// Module      : shim_sts_sync_field
// Description : One status field: multi-flop synchroniser, previous-sample
//               register, saturating stability counter and debounced live
//               value.
// Ports       : clk_i        clock
//               rst_i        synchronous active-high reset
//               din_i        asynchronous field input
//               live_o       debounced value (registered)
//               live_next_o  value live_o takes on the next edge
//               stable_o     stability counter saturated (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shim_sts_sync_field
   import shim_sts_pkg::*;
#(
   parameter int FIELD_W      = 8,
   parameter int DEPTH        = DEFAULT_SYNC_DEPTH,
   parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [FIELD_W-1:0] din_i,
   output logic [FIELD_W-1:0] live_o,
   output logic [FIELD_W-1:0] live_next_o,
   output logic               stable_o
);

   localparam int               CNT_W   = $clog2(STABLE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

   logic [FIELD_W-1:0] sync_q [DEPTH];
   logic [FIELD_W-1:0] last;
   logic [FIELD_W-1:0] prev_q;
   logic [FIELD_W-1:0] live_q, live_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               stable_q;

   always_comb begin
      last  = sync_q[DEPTH-1];
      cnt_d = '0;
      if (last == prev_q) begin
         // Saturate rather than wrap so a long-settled field stays settled.
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      end
      // Only a value that has been seen unchanged for the full count is
      // promoted; otherwise the last accepted value is held.
      live_d = (cnt_q == CNT_MAX) ? prev_q : live_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            sync_q[k] <= '0;
         end
         prev_q   <= '0;
         cnt_q    <= '0;
         live_q   <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q[0] <= din_i;
         for (int k = 1; k < DEPTH; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prev_q   <= last;
         cnt_q    <= cnt_d;
         live_q   <= live_d;
         stable_q <= (cnt_d == CNT_MAX);
      end
   end

   assign live_o      = live_q;
   assign live_next_o = live_d;
   assign stable_o    = stable_q;

endmodule : shim_sts_sync_field

`default_nettype wire

// File: rtl/shim_sts_sync_latch.sv
// ============================================================================
// Module      : shim_sts_sync_latch
// Description : Status CDC front-end. Synchronises and debounces NUM_FIELDS
//               status fields from a foreign clock domain and presents live
//               value, rising-edge pulses, sticky bits with masked clear and
//               a maskable interrupt in the aclk domain.
// Ports       : aclk, areset           clock / synchronous active-high reset
//               din                    async status bus (field f at f*FIELD_W)
//               clr, clr_mask          sticky clear strobe and bit mask
//               irq_mask               sticky bits contributing to irq
//               sts_live, sts_rise     debounced value, 0->1 pulses
//               sts_sticky             latched status bits
//               field_stable           per-field settled flag
//               irq                    registered |(sts_sticky & irq_mask)
//               first_fault_vld/_idx   only with SHIM_STS_FIRST_FAULT_EN
// Options     : `define SHIM_STS_FIRST_FAULT_EN adds first-fault capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shim_sts_sync_latch
   import shim_sts_pkg::*;
#(
   parameter int NUM_FIELDS   = 8,
   parameter int FIELD_W      = 8,
   parameter int DEPTH        = DEFAULT_SYNC_DEPTH,
   parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [NUM_FIELDS*FIELD_W-1:0] din,
   input  logic                          clr,
   input  logic [NUM_FIELDS*FIELD_W-1:0] clr_mask,
   input  logic [NUM_FIELDS*FIELD_W-1:0] irq_mask,
   output logic [NUM_FIELDS*FIELD_W-1:0] sts_live,
   output logic [NUM_FIELDS*FIELD_W-1:0] sts_rise,
   output logic [NUM_FIELDS*FIELD_W-1:0] sts_sticky,
   output logic [NUM_FIELDS-1:0]         field_stable,
   output logic                          irq
`ifdef SHIM_STS_FIRST_FAULT_EN
   ,
   output logic                                 first_fault_vld,
   output logic [clog2_min1(NUM_FIELDS)-1:0]    first_fault_idx
`endif
);

   localparam int NW = NUM_FIELDS * FIELD_W;

   logic [NW-1:0] live, live_next;
   logic [NW-1:0] clr_bits;
   logic [NW-1:0] rise_q, rise_d;
   logic [NW-1:0] sticky_q, sticky_d;
   logic          irq_q, irq_d;

   for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
      shim_sts_sync_field #(
         .FIELD_W      (FIELD_W),
         .DEPTH        (DEPTH),
         .STABLE_COUNT (STABLE_COUNT)
      ) u_field (
         .clk_i       (aclk),
         .rst_i       (areset),
         .din_i       (din[f*FIELD_W +: FIELD_W]),
         .live_o      (live[f*FIELD_W +: FIELD_W]),
         .live_next_o (live_next[f*FIELD_W +: FIELD_W]),
         .stable_o    (field_stable[f])
      );
   end

   always_comb begin
      clr_bits = clr ? clr_mask : '0;
      // OR-ing live in after the clear makes a still-present fault win.
      sticky_d = (sticky_q & ~clr_bits) | live;
      // Using next-live aligns the pulse with the first cycle live reads 1.
      rise_d   = live_next & ~live;
      irq_d    = |(sticky_q & irq_mask);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rise_q   <= '0;
         sticky_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         rise_q   <= rise_d;
         sticky_q <= sticky_d;
         irq_q    <= irq_d;
      end
   end

   assign sts_live   = live;
   assign sts_rise   = rise_q;
   assign sts_sticky = sticky_q;
   assign irq        = irq_q;

`ifdef SHIM_STS_FIRST_FAULT_EN
   localparam int IDX_W = clog2_min1(NUM_FIELDS);

   logic [NUM_FIELDS-1:0] new_fault;
   logic                  ff_vld_q, ff_vld_d;
   logic [IDX_W-1:0]      ff_idx_q, ff_idx_d;

   always_comb begin
      ff_vld_d = ff_vld_q;
      ff_idx_d = ff_idx_q;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         new_fault[f] = (sticky_q[f*FIELD_W +: FIELD_W] == '0) &&
                        (sticky_d[f*FIELD_W +: FIELD_W] != '0);
      end
      if (clr && (&clr_mask)) begin
         ff_vld_d = 1'b0;
         ff_idx_d = '0;
      end else if (!ff_vld_q && (|new_fault)) begin
         ff_vld_d = 1'b1;
         // Descending scan so the lowest faulting index is the last written.
         for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
            if (new_fault[f]) begin
               ff_idx_d = IDX_W'(f);
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         ff_vld_q <= 1'b0;
         ff_idx_q <= '0;
      end else begin
         ff_vld_q <= ff_vld_d;
         ff_idx_q <= ff_idx_d;
      end
   end

   assign first_fault_vld = ff_vld_q;
   assign first_fault_idx = ff_idx_q;
`endif

endmodule : shim_sts_sync_latch

`default_nettype wire

// File: tb/tb_shim_sts_sync_latch.sv
// ============================================================================
// Module      : tb_shim_sts_sync_latch
// Description : Self-checking bench for shim_sts_sync_latch. A sample-history
//               reference model predicts every output each cycle and queues
//               the prediction; a monitor pops and compares on the falling
//               edge. Directed sequences add spot checks on latency, glitch
//               rejection, sticky clear and irq masking.
// Options     : SHIM_STS_FIRST_FAULT_EN enables first-fault checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shim_sts_sync_latch;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int NW = N * W;
   localparam int D  = 3;
   localparam int SC = 2;
   localparam int HL = D + SC + 2;

   logic          aclk = 1'b0;
   logic          areset;
   logic [NW-1:0] din, clr_mask, irq_mask;
   logic          clr;
   logic [NW-1:0] sts_live, sts_rise, sts_sticky;
   logic [N-1:0]  field_stable;
   logic          irq;
`ifdef SHIM_STS_FIRST_FAULT_EN
   logic          first_fault_vld;
   logic [2:0]    first_fault_idx;
`endif

   shim_sts_sync_latch #(
      .NUM_FIELDS(N), .FIELD_W(W), .DEPTH(D), .STABLE_COUNT(SC)
   ) dut (
      .aclk(aclk), .areset(areset), .din(din), .clr(clr),
      .clr_mask(clr_mask), .irq_mask(irq_mask),
      .sts_live(sts_live), .sts_rise(sts_rise), .sts_sticky(sts_sticky),
      .field_stable(field_stable), .irq(irq)
`ifdef SHIM_STS_FIRST_FAULT_EN
      , .first_fault_vld(first_fault_vld), .first_fault_idx(first_fault_idx)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [NW-1:0] live;
      logic [NW-1:0] rise;
      logic [NW-1:0] sticky;
      logic [N-1:0]  stable;
      logic          irq;
      logic          ffv;
      logic [2:0]    ffi;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   // hist[f][k] is the din sample taken k edges ago. A value reaches live once
   // SC+1 consecutive samples, aged D+1 edges, all agree.
   logic [W-1:0]  hist [N][HL];
   int            edges;
   logic [NW-1:0] m_live, m_rise, m_sticky;
   logic [N-1:0]  m_stable;
   logic          m_irq, m_ffv;
   logic [2:0]    m_ffi;

   initial begin
      exp_t          e;
      logic [NW-1:0] old_live, old_sticky, new_live;
      logic          eq;
      forever begin
         @(posedge aclk);
         if (areset) begin
            for (int f = 0; f < N; f++)
               for (int k = 0; k < HL; k++) hist[f][k] = '0;
            edges = 0; m_live = '0; m_rise = '0; m_sticky = '0;
            m_stable = '0; m_irq = 1'b0; m_ffv = 1'b0; m_ffi = '0;
         end else begin
            old_live   = m_live;
            old_sticky = m_sticky;
            if (edges < 1000) edges++;
            for (int f = 0; f < N; f++) begin
               for (int k = HL - 1; k > 0; k--) hist[f][k] = hist[f][k-1];
               hist[f][0] = din[f*W +: W];
               eq = 1'b1;
               for (int k = D + 1; k <= D + 1 + SC; k++)
                  if (hist[f][k] != hist[f][D+1]) eq = 1'b0;
               new_live[f*W +: W] = eq ? hist[f][D+1] : old_live[f*W +: W];
               eq = 1'b1;
               for (int k = D; k <= D + SC; k++)
                  if (hist[f][k] != hist[f][D]) eq = 1'b0;
               m_stable[f] = eq && (edges >= SC);
            end
            m_rise   = new_live & ~old_live;
            m_sticky = (old_sticky & ~(clr ? clr_mask : '0)) | old_live;
            m_irq    = |(old_sticky & irq_mask);
            m_live   = new_live;
            if (clr && (&clr_mask)) begin
               m_ffv = 1'b0; m_ffi = '0;
            end else if (!m_ffv) begin
               for (int f = N - 1; f >= 0; f--) begin
                  if (old_sticky[f*W +: W] == '0 && m_sticky[f*W +: W] != '0) begin
                     m_ffv = 1'b1; m_ffi = 3'(f);
                  end
               end
            end
         end
         e.live = m_live; e.rise = m_rise; e.sticky = m_sticky;
         e.stable = m_stable; e.irq = m_irq; e.ffv = m_ffv; e.ffi = m_ffi;
         sb_q.push_back(e);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_empty: actual=no prediction required=one per cycle at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk("sb_live",   sts_live,   e.live);
            chk("sb_rise",   sts_rise,   e.rise);
            chk("sb_sticky", sts_sticky, e.sticky);
            chk("sb_stable", 64'(field_stable), 64'(e.stable));
            chk("sb_irq",    64'(irq),   64'(e.irq));
`ifdef SHIM_STS_FIRST_FAULT_EN
            chk("sb_ffv",    64'(first_fault_vld), 64'(e.ffv));
            chk("sb_ffi",    64'(first_fault_idx), 64'(e.ffi));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [NW-1:0] saved;
      areset = 1'b1; din = '1; clr = 1'b0; clr_mask = '0; irq_mask = '0;

      // Reset with all-ones input: everything stays 0, then 7-edge latency.
      repeat (3) begin
         @(posedge aclk); #1;
         chk("rst_live",   sts_live,   '0);
         chk("rst_sticky", sts_sticky, '0);
         chk("rst_misc",   {sts_rise[54:0], field_stable, irq}, '0);
      end
      @(negedge aclk) areset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(posedge aclk); #1;
         if (e == 6) chk("lat_live_e6", sts_live, '0);
         if (e == 7) chk("lat_live_e7", sts_live, '1);
      end

      // Return to zero and clear sticky bits.
      @(negedge aclk) din = '0;
      repeat (10) @(negedge aclk);
      clr = 1'b1; clr_mask = '1;
      @(negedge aclk) clr = 1'b0; clr_mask = '0;
      repeat (3) @(negedge aclk);

      // Field 2 = 0x5A: appears exactly 7 edges later with a one-cycle rise.
      din = 64'h0000_0000_005A_0000;
      for (int e = 1; e <= 8; e++) begin
         @(posedge aclk); #1;
         if (e == 6) chk("f2_live_e6", 64'(sts_live[23:16]), 64'h00);
         if (e == 7) begin
            chk("f2_live_e7", 64'(sts_live[23:16]), 64'h5A);
            chk("f2_rise_e7", 64'(sts_rise[23:16]), 64'h5A);
         end
         if (e == 8) chk("f2_rise_e8", 64'(sts_rise[23:16]), 64'h00);
      end

      // Single-cycle glitch on bit 0 must be rejected.
      repeat (5) @(negedge aclk);
      din[0] = 1'b1;
      @(negedge aclk) din[0] = 1'b0;
      repeat (12) @(negedge aclk);
      chk("glitch_live",   64'(sts_live[7:0]),   64'h00);
      chk("glitch_sticky", 64'(sts_sticky[7:0]), 64'h00);

      // Sticky latch, no-op clear, masked clear, set-wins.
      din[40] = 1'b1;
      repeat (10) @(negedge aclk);
      din[40] = 1'b0;
      repeat (10) @(negedge aclk);
      chk("stk_held", 64'(sts_sticky[40]), 64'd1);
      chk("stk_live", 64'(sts_live[40]),   64'd0);
      saved = sts_sticky;
      clr = 1'b1; clr_mask = '0;
      @(posedge aclk); #1;
      chk("stk_clr_nomask", sts_sticky, saved);
      @(negedge aclk) clr_mask = 64'd1 << 40;
      @(posedge aclk); #1;
      chk("stk_cleared", 64'(sts_sticky[40]), 64'd0);
      @(negedge aclk) begin clr = 1'b0; clr_mask = '0; din[40] = 1'b1; end
      repeat (10) @(negedge aclk);
      clr = 1'b1; clr_mask = 64'd1 << 40;
      @(posedge aclk); #1;
      chk("stk_set_wins", 64'(sts_sticky[40]), 64'd1);
      @(negedge aclk) begin clr = 1'b0; clr_mask = '0; end

      // irq masking.
      din[9] = 1'b1;
      repeat (10) @(negedge aclk);
      chk("irq_stk9",   64'(sts_sticky[9]), 64'd1);
      chk("irq_masked", 64'(irq), 64'd0);
      irq_mask = 64'd1 << 9;
      @(posedge aclk); #1;
      chk("irq_unmasked", 64'(irq), 64'd1);

`ifdef SHIM_STS_FIRST_FAULT_EN
      @(negedge aclk) begin areset = 1'b1; din = '0; irq_mask = '0; end
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      repeat (12) @(negedge aclk);
      din = (64'd1 << 24) | (64'd1 << 48);
      repeat (12) @(negedge aclk);
      chk("ff_vld",  64'(first_fault_vld), 64'd1);
      chk("ff_idx3", 64'(first_fault_idx), 64'd3);
      din[8] = 1'b1;
      repeat (12) @(negedge aclk);
      chk("ff_idx_hold", 64'(first_fault_idx), 64'd3);
      clr = 1'b1; clr_mask = '1;
      @(posedge aclk); #1;
      chk("ff_clr_vld", 64'(first_fault_vld), 64'd0);
      chk("ff_clr_idx", 64'(first_fault_idx), 64'd0);
      @(negedge aclk) begin clr = 1'b0; clr_mask = '0; end
`endif

      // Randomised traffic with a mid-run reset.
      for (int c = 0; c < 400; c++) begin
         @(negedge aclk);
         areset = (c >= 200 && c < 202);
         for (int f = 0; f < N; f++)
            if ($urandom_range(9) == 0) din[f*W +: W] = W'($urandom);
         if ($urandom_range(15) == 0) din[$urandom_range(NW-1)] ^= 1'b1;
         clr      = ($urandom_range(7) == 0);
         clr_mask = ($urandom_range(3) == 0) ? '1 : {$urandom, $urandom};
         if ($urandom_range(49) == 0) irq_mask = {$urandom, $urandom};
      end
      @(negedge aclk) begin clr = 1'b0; areset = 1'b0; end
      repeat (3) @(negedge aclk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_shim_sts_sync_latch

`default_nettype wire
